// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute control FSM that owns the PC
// Optional single-step mode: define SEQ_SINGLE_STEP_EN (adds step port and WAIT_STEP state).
module instr_sequencer #(
  parameter int unsigned       ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [15:0]       HALT_OPCODE = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr_out,
  input  logic              dec_isjump,
  input  logic              dec_isjumpz,
  input  logic              dec_write,
  input  logic              dec_show,
  input  logic [7:0]        dec_addr,
  input  logic              alu_zero,
  output logic              rf_we,
  output logic              show_valid,
  input  logic              show_ready,
  output logic              busy,
  output logic              halted
);

`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    st_idle, st_fetch, st_decode, st_exec, st_wb, st_show, st_halt, st_wait_step
  } state_t;
  localparam state_t RESUME_ST = st_wait_step;
`else
  typedef enum logic [2:0] {
    st_idle, st_fetch, st_decode, st_exec, st_wb, st_show, st_halt
  } state_t;
  localparam state_t RESUME_ST = st_fetch;
`endif

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc, jump_tgt;
  logic [15:0]       instr_n;
  logic              zero_flag, zero_flag_n;

  assign pc_inc    = pc + ADDR_W'(1);
  assign imem_addr = pc;

  generate
    if (ADDR_W >= 8) begin : g_wide_tgt
      assign jump_tgt = ADDR_W'(dec_addr);
    end else begin : g_narrow_tgt
      assign jump_tgt = dec_addr[ADDR_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= st_idle;
      pc        <= RESET_PC;
      instr_out <= '0;
      zero_flag <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      instr_out <= instr_n;
      zero_flag <= zero_flag_n;
    end
  end

  // Outputs are decoded from the state so an async reset drops them at once.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    instr_n     = instr_out;
    zero_flag_n = zero_flag;
    imem_req    = 1'b0;
    rf_we       = 1'b0;
    show_valid  = 1'b0;
    busy        = 1'b1;
    halted      = 1'b0;
    case (state)
      st_idle, st_halt: begin
        busy   = 1'b0;
        halted = (state == st_halt);
        if (start) begin
          pc_n    = RESET_PC;
          state_n = st_fetch;
        end
      end
      st_fetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_n = imem_rdata;
          state_n = st_decode;
        end
      end
      st_decode: state_n = st_exec;
      st_exec: begin
        // Halt beats every decoder flag; jumps leave zero_flag untouched.
        if (instr_out == HALT_OPCODE) begin
          state_n = st_halt;
        end else if (dec_isjump) begin
          pc_n    = jump_tgt;
          state_n = RESUME_ST;
        end else if (dec_isjumpz) begin
          pc_n    = zero_flag ? jump_tgt : pc_inc;
          state_n = RESUME_ST;
        end else if (dec_show) begin
          state_n = st_show;
        end else if (dec_write) begin
          state_n = st_wb;
        end else begin
          zero_flag_n = alu_zero;
          pc_n        = pc_inc;
          state_n     = RESUME_ST;
        end
      end
      st_wb: begin
        rf_we       = 1'b1;
        zero_flag_n = alu_zero;
        pc_n        = pc_inc;
        state_n     = RESUME_ST;
      end
      st_show: begin
        show_valid = 1'b1;
        if (show_ready) begin
          pc_n    = pc_inc;
          state_n = RESUME_ST;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      st_wait_step: begin
        if (step) state_n = st_fetch;
      end
`endif
      default: state_n = st_idle;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed table, hand sequences and randomized ISA-level check
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr_out;
  logic        dec_isjump, dec_isjumpz, dec_write, dec_show, alu_zero;
  logic [7:0]  dec_addr;
  logic        rf_we, show_valid, busy, halted;
  logic        show_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step = 1'b1;
`endif

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .dec_isjump(dec_isjump), .dec_isjumpz(dec_isjumpz),
    .dec_write(dec_write), .dec_show(dec_show), .dec_addr(dec_addr), .alu_zero(alu_zero),
    .rf_we(rf_we), .show_valid(show_valid), .show_ready(show_ready),
    .busy(busy), .halted(halted)
  );

  initial forever #5 clk = ~clk;

  // Toy ISA: op=[15:12], alu_zero=[8], target=[7:0]; ops 6/7/8 raise several flags at once.
  logic [3:0] op;
  assign op          = instr_out[15:12];
  assign dec_isjump  = (op == 4'd1) || (op == 4'd6);
  assign dec_isjumpz = (op == 4'd2) || (op == 4'd7);
  assign dec_show    = (op == 4'd3) || (op == 4'd6) || (op == 4'd8);
  assign dec_write   = (op == 4'd4) || (op == 4'd6) || (op == 4'd7) || (op == 4'd8);
  assign dec_addr    = instr_out[7:0];
  assign alu_zero    = instr_out[8];

  typedef struct { int c; int a; } ev_t;
  typedef struct {
    logic [15:0] i0, i1;
    int fd0, sd0, a1, t1, a2, t2, nwe, w0, nsv;
  } vec_t;

  logic [15:0] mem [0:255];
  int   fd [0:255];
  int   sd [0:255];
  int   cyc = 0, t0 = 0;
  ev_t  fq[$], efq[$];
  int   wq[$], sq[$], ewq[$], esq[$];
  int   nsv, nboth, halt_c, ehalt;
  bit   in_f, in_s;
  int   fl, sl, fidx, sidx;
  int   n_cmp = 0, n_bad = 0;
  vec_t vt [12];

  initial forever @(posedge clk) cyc++;

  // Memory/display responders and event monitor, all at the falling edge.
  initial forever begin
    @(negedge clk);
    imem_ack   = 1'b0;
    show_ready = 1'b0;
    if (!rst_n) begin
      in_f = 0; in_s = 0; fidx = 0; sidx = 0;
    end else begin
      if (imem_req) begin
        if (!in_f) begin in_f = 1; fl = fd[fidx & 255]; end
        if (fl == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          in_f = 0;
          fidx++;
          fq.push_back('{cyc, int'(imem_addr)});
        end else fl--;
      end
      if (show_valid) begin
        nsv++;
        if (!in_s) begin in_s = 1; sl = sd[sidx & 255]; end
        if (sl == 0) begin
          show_ready = 1'b1;
          in_s = 0;
          sidx++;
          sq.push_back(cyc);
        end else sl--;
      end
      if (rf_we) wq.push_back(cyc);
      if (rf_we && show_valid) nboth++;
      if (halted && halt_c < 0) halt_c = cyc;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic clear_logs();
    fq.delete(); wq.delete(); sq.delete();
    nsv = 0; nboth = 0; halt_c = -1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fetches(input int nf, input int budget, output bit done);
    done = 0;
    for (int k = 0; k < budget; k++) begin
      if (fq.size() >= nf || halt_c >= 0) begin done = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic run_prog(input int nf, input int budget, output bit done);
    @(negedge clk);
    rst_n = 1'b0;
    clear_logs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_start();
    wait_fetches(nf, budget, done);
  endtask

  function automatic int rel_f(input int k);
    return (fq.size() > k) ? fq[k].c - t0 : -1;
  endfunction

  function automatic int addr_f(input int k);
    return (fq.size() > k) ? fq[k].a : -1;
  endfunction

  // Instruction-level reference: walks the program and predicts event cycles.
  function automatic void ref_model(input int nf);
    int t, pc, zf, j, ta, te, opi, a;
    logic [15:0] ins;
    t = 0; pc = 0; zf = 0; j = 0;
    efq.delete(); ewq.delete(); esq.delete(); ehalt = -1;
    for (int n = 0; n < nf; n++) begin
      ta = t + fd[n];
      efq.push_back('{ta, pc});
      if (n == nf - 1) break;
      ins = mem[pc];
      opi = int'(ins[15:12]);
      a   = int'(ins[7:0]);
      te  = ta + 2;
      if (ins == 16'hFFFF) begin ehalt = te + 1; break; end
      case (opi)
        1, 6: begin pc = a; t = te + 1; end
        2, 7: begin pc = (zf != 0) ? a : (pc + 1) % 256; t = te + 1; end
        3, 8: begin
          esq.push_back(te + 1 + sd[j]);
          t = te + 2 + sd[j];
          j++;
          pc = (pc + 1) % 256;
        end
        4: begin ewq.push_back(te + 1); zf = int'(ins[8]); pc = (pc + 1) % 256; t = te + 2; end
        default: begin zf = int'(ins[8]); pc = (pc + 1) % 256; t = te + 1; end
      endcase
    end
  endfunction

  function automatic logic [15:0] rand_instr();
    int r;
    logic [3:0] o;
    r = int'($urandom_range(0, 15));
    case (r)
      0, 1:     o = 4'd1;
      2, 3:     o = 4'd2;
      4:        o = 4'd3;
      5:        o = 4'd8;
      6, 7, 8:  o = 4'd4;
      12:       o = 4'd6;
      13:       o = 4'd7;
      14:       o = 4'd0;
      15:       return 16'hFFFF;
      default:  o = 4'd5;
    endcase
    return {o, 3'b000, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31))};
  endfunction

  task automatic fill_filler();
    for (int i = 0; i < 256; i++) begin mem[i] = 16'h5000; fd[i] = 0; sd[i] = 0; end
  endtask

  initial begin
    bit done;
    int nf;
    //            i0        i1        fd0 sd0 a1     t1 a2     t2 nwe w0  nsv
    vt[0]  = '{16'h4000, 16'h5000, 0, 0, 1,     4, 2,     7,  1,  3, 0};
    vt[1]  = '{16'h1020, 16'h5000, 0, 0, 'h20,  3, 'h21,  6,  0, -1, 0};
    vt[2]  = '{16'h4100, 16'h2010, 0, 0, 1,     4, 'h10,  7,  1,  3, 0};
    vt[3]  = '{16'h4000, 16'h2010, 0, 0, 1,     4, 2,     7,  1,  3, 0};
    vt[4]  = '{16'h5100, 16'h2010, 0, 0, 1,     3, 'h10,  6,  0, -1, 0};
    vt[5]  = '{16'h3000, 16'h5000, 0, 5, 1,     9, 2,     12, 0, -1, 6};
    vt[6]  = '{16'h3000, 16'h5000, 0, 0, 1,     4, 2,     7,  0, -1, 1};
    vt[7]  = '{16'h4000, 16'h5000, 2, 0, 1,     6, 2,     9,  1,  5, 0};
    vt[8]  = '{16'h6030, 16'h5000, 0, 0, 'h30,  3, 'h31,  6,  0, -1, 0};
    vt[9]  = '{16'h7040, 16'h5000, 0, 0, 1,     3, 2,     6,  0, -1, 0};
    vt[10] = '{16'h8000, 16'h5000, 0, 1, 1,     5, 2,     8,  0, -1, 2};
    vt[11] = '{16'h10FF, 16'h5000, 0, 0, 'hFF,  3, 0,     6,  0, -1, 0};

    fill_filler();
    clear_logs();
    #1;
    chk("reset_outputs", {22'd0, imem_req, rf_we, show_valid, busy, halted, imem_addr[4:0]}, 32'd0);
    chk("reset_instr", {16'd0, instr_out}, 32'd0);
    chk("reset_addr", {24'd0, imem_addr}, 32'd0);

    for (int v = 0; v < 12; v++) begin
      fill_filler();
      mem[0] = vt[v].i0;
      mem[vt[v].a1] = vt[v].i1;
      fd[0] = vt[v].fd0;
      sd[0] = vt[v].sd0;
      run_prog(3, 100, done);
      chk($sformatf("v%0d_done", v), done, 1);
      chk($sformatf("v%0d_a0", v), addr_f(0), 0);
      chk($sformatf("v%0d_t0", v), rel_f(0), vt[v].fd0);
      chk($sformatf("v%0d_a1", v), addr_f(1), vt[v].a1);
      chk($sformatf("v%0d_t1", v), rel_f(1), vt[v].t1);
      chk($sformatf("v%0d_a2", v), addr_f(2), vt[v].a2);
      chk($sformatf("v%0d_t2", v), rel_f(2), vt[v].t2);
      chk($sformatf("v%0d_nwe", v), wq.size(), vt[v].nwe);
      chk($sformatf("v%0d_w0", v), (wq.size() > 0) ? wq[0] - t0 : -1, vt[v].w0);
      chk($sformatf("v%0d_nsv", v), nsv, vt[v].nsv);
      chk($sformatf("v%0d_excl", v), nboth, 0);
    end

    // Halt, then restart from RESET_PC without a reset.
    fill_filler();
    mem[0] = 16'hFFFF;
    run_prog(99, 50, done);
    chk("halt_done", done, 1);
    chk("halt_cycle", halt_c - t0, 3);
    @(negedge clk);
    chk("halt_flags", {busy, halted, imem_req}, 3'b010);
    do_start();
    chk("restart_busy", busy, 1);
    wait_fetches(2, 20, done);
    chk("restart_addr", addr_f(1), 0);
    chk("restart_time", rel_f(1), 0);

    // Start pulsed mid-SHOW must be ignored.
    fill_filler();
    mem[0] = 16'h3000;
    sd[0] = 5;
    run_prog(1, 20, done);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_fetches(2, 40, done);
    chk("ign_start_a1", addr_f(1), 1);
    chk("ign_start_t1", rel_f(1), 9);

    // Async reset while a fetch is outstanding.
    fill_filler();
    mem[0] = 16'h1040;
    fd[1] = 1000;
    run_prog(1, 20, done);
    repeat (5) @(negedge clk);
    chk("midfetch_req", {imem_req, busy, imem_addr}, {2'b11, 8'h40});
    #2 rst_n = 1'b0;
    #1;
    chk("midfetch_rst", {imem_req, busy, rf_we, show_valid, imem_addr}, 12'h000);
    @(negedge clk);
    clear_logs();
    fd[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    wait_fetches(1, 20, done);
    chk("midfetch_refetch_a", addr_f(0), 0);
    chk("midfetch_refetch_t", rel_f(0), 0);

    // Randomized programs against the instruction-level model.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = rand_instr();
        fd[i] = int'($urandom_range(0, 2));
        sd[i] = int'($urandom_range(0, 3));
      end
      ref_model(21);
      nf = (ehalt >= 0) ? 9999 : efq.size();
      run_prog(nf, 600, done);
      chk($sformatf("r%0d_done", r), done, 1);
      chk($sformatf("r%0d_nfetch", r), fq.size(), efq.size());
      for (int k = 0; k < efq.size() && k < fq.size(); k++) begin
        chk($sformatf("r%0d_f%0d_addr", r, k), fq[k].a, efq[k].a);
        chk($sformatf("r%0d_f%0d_cyc", r, k), fq[k].c - t0, efq[k].c);
      end
      chk($sformatf("r%0d_nwe", r), wq.size(), ewq.size());
      for (int k = 0; k < ewq.size() && k < wq.size(); k++)
        chk($sformatf("r%0d_we%0d", r, k), wq[k] - t0, ewq[k]);
      chk($sformatf("r%0d_nshow", r), sq.size(), esq.size());
      for (int k = 0; k < esq.size() && k < sq.size(); k++)
        chk($sformatf("r%0d_sh%0d", r, k), sq[k] - t0, esq[k]);
      chk($sformatf("r%0d_halt", r), (halt_c >= 0) ? halt_c - t0 : -1, ehalt);
      chk($sformatf("r%0d_excl", r), nboth, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
